// File: rtl/calc_pkg.sv
// Shared opcode constants and sequencer state encoding for the calculator datapath.
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_MUL  = 2'b10,
      S_DONE = 2'b11
   } state_t;

endpackage

// File: rtl/calc_seq_datapath.sv
// Operand/accumulator registers, iteration counter and the WIDTH-bit ripple adder/subtractor.
// Optional signed-overflow flag is built only when CALC_SEQ_OVF_EN is defined.
module calc_seq_datapath
   import calc_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic               capture,
   input  logic               capture_ill,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               iter_done,
   output logic [2*WIDTH-1:0] result,
   output logic               err
`ifdef CALC_SEQ_OVF_EN
   ,
   output logic               ovf
`endif
);

   localparam int IW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [1:0]         op_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [IW-1:0]      iter_q;

   logic [WIDTH-1:0]   add_a;
   logic [WIDTH-1:0]   add_b;
   logic               add_cin;
   logic [WIDTH-1:0]   sum;
   logic               cout;

   // Mul reuses the adder on the accumulator's upper half; b_q doubles as the multiplier shifter.
   always_comb begin
      add_a   = a_q;
      add_b   = b_q;
      add_cin = 1'b0;
      case (op_q)
         OP_SUB: begin
            add_b   = ~b_q;
            add_cin = 1'b1;
         end
         OP_MUL: begin
            add_a = acc_q[2*WIDTH-1:WIDTH];
            add_b = b_q[0] ? a_q : '0;
         end
         default: ;
      endcase
   end

   always_comb begin
      logic c;
      c   = add_cin;
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = add_a[i] ^ add_b[i] ^ c;
         c      = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
      end
      cout = c;
   end

   assign iter_done = (iter_q == IW'(WIDTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_ADD;
         acc_q  <= '0;
         iter_q <= '0;
         result <= '0;
         err    <= 1'b0;
`ifdef CALC_SEQ_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         if (load) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op;
            acc_q  <= '0;
            iter_q <= '0;
         end else if (step && !iter_done) begin
            acc_q  <= {cout, sum, acc_q[WIDTH-1:1]};
            b_q    <= b_q >> 1;
            iter_q <= iter_q + 1'b1;
         end

         if (capture_ill) begin
            result <= '0;
            err    <= 1'b1;
`ifdef CALC_SEQ_OVF_EN
            ovf    <= 1'b0;
`endif
         end else if (capture) begin
            result <= (op_q == OP_MUL) ? acc_q : (2*WIDTH)'({cout, sum});
            err    <= 1'b0;
`ifdef CALC_SEQ_OVF_EN
            // Same-sign operands into the adder producing a different-sign sum.
            ovf    <= (op_q != OP_MUL) && (add_a[WIDTH-1] == add_b[WIDTH-1])
                      && (sum[WIDTH-1] != add_a[WIDTH-1]);
`endif
         end
      end
   end

endmodule

// File: rtl/calc_op_sequencer.sv
// Add/sub/mul sequencer around the shared ripple adder; FSM here, datapath in calc_seq_datapath.
// Optional ovf port is present only when CALC_SEQ_OVF_EN is defined.
module calc_op_sequencer
   import calc_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               err
`ifdef CALC_SEQ_OVF_EN
   ,
   output logic               ovf
`endif
);

   state_t state_q;
   state_t state_d;
   logic   load;
   logic   step;
   logic   capture;
   logic   capture_ill;
   logic   iter_done;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // MUL holds one extra cycle after the last iteration so mul completes at start+WIDTH+2.
   always_comb begin
      state_d     = state_q;
      load        = 1'b0;
      step        = 1'b0;
      capture     = 1'b0;
      capture_ill = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load = 1'b1;
               case (op)
                  OP_ADD, OP_SUB: state_d = S_EXEC;
                  OP_MUL:         state_d = S_MUL;
                  default: begin
                     capture_ill = 1'b1;
                     state_d     = S_DONE;
                  end
               endcase
            end
         end
         S_EXEC: begin
            busy    = 1'b1;
            capture = 1'b1;
            state_d = S_DONE;
         end
         S_MUL: begin
            busy = 1'b1;
            step = 1'b1;
            if (iter_done) begin
               capture = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   calc_seq_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .step        (step),
      .capture     (capture),
      .capture_ill (capture_ill),
      .op          (op),
      .a           (a),
      .b           (b),
      .iter_done   (iter_done),
      .result      (result),
      .err         (err)
`ifdef CALC_SEQ_OVF_EN
      ,
      .ovf         (ovf)
`endif
   );

endmodule
